// File: rtl/pixel_sync_fifo.sv
// pixel_sync_fifo: single-clock RGB565 word FIFO with occupancy count,
// almost-full/almost-empty flags, sticky overflow/underflow, synchronous
// flush and an optional first-word-fall-through read port.
// Optional feature macro: PIXEL_SYNC_FIFO_PEAK_EN enables the high-water
// mark register on peak_count_o; without it peak_count_o is tied to zero.
module pixel_sync_fifo #(
    parameter int DATA_WIDTH      = 16,
    parameter int ADDR_WIDTH      = 9,
    parameter int ALMOST_FULL_TH  = (2 ** ADDR_WIDTH) - 4,
    parameter int ALMOST_EMPTY_TH = 4,
    parameter bit FWFT            = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clear_i,
    input  logic                  wr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic [ADDR_WIDTH:0]   peak_count_o
);

    localparam int                DEPTH   = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_TH_C = (ADDR_WIDTH + 1)'(ALMOST_FULL_TH);
    localparam logic [ADDR_WIDTH:0] AE_TH_C = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_TH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] w_ptr_q, w_ptr_d;
    logic [ADDR_WIDTH-1:0] r_ptr_q, r_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic empty;
    logic full;
    logic rd_acc;
    logic wr_acc;

    // Flags decode the registered count, so they follow an accepted op by one cycle.
    assign empty          = (count_q == '0);
    assign full           = (count_q == DEPTH_C);
    assign empty_o        = empty;
    assign full_o         = full;
    assign almost_full_o  = (count_q >= AF_TH_C);
    assign almost_empty_o = (count_q <= AE_TH_C);
    assign count_o        = count_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // A write into a full FIFO is still accepted when a read frees a slot the same cycle.
    assign rd_acc = rd_i & ~empty;
    assign wr_acc = wr_i & (~full | rd_acc);

    // Next-state for pointers, occupancy and sticky error bits; flush wins over traffic.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no latch is inferred.
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (clear_i) begin
            w_ptr_d     = '0;
            r_ptr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_acc) w_ptr_d = w_ptr_q + 1'b1;
            if (rd_acc) r_ptr_d = r_ptr_q + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            overflow_d  = overflow_q  | (wr_i & ~wr_acc);
            underflow_d = underflow_q | (rd_i & ~rd_acc);
        end
    end

    // Control state register; reset empties the FIFO immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array write port.
    always_ff @(posedge clk_i) begin
        // NOTE: the array is deliberately not reset; pointers and count define which words are live.
        if (wr_acc && !clear_i) mem_q[w_ptr_q] <= data_i;
    end

    generate
        if (FWFT) begin : g_fwft
            // Head word is presented combinationally; rd_i just pops it.
            always_comb begin
                data_o  = empty ? '0 : mem_q[r_ptr_q];
                valid_o = ~empty;
            end
        end else begin : g_reg_read
            logic [DATA_WIDTH-1:0] data_q, data_d;
            logic                  valid_q, valid_d;

            // Registered read: the array read happens before the same-edge write, giving the old word.
            always_comb begin
                data_d  = data_q;
                valid_d = 1'b0;
                if (clear_i) begin
                    data_d = '0;
                end else if (rd_acc) begin
                    data_d  = mem_q[r_ptr_q];
                    valid_d = 1'b1;
                end
            end

            // Read data register.
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign data_o  = data_q;
            assign valid_o = valid_q;
        end
    endgenerate

`ifdef PIXEL_SYNC_FIFO_PEAK_EN
    logic [ADDR_WIDTH:0] peak_q, peak_d;

    // High-water mark tracks the next count so it never lags the occupancy.
    always_comb begin
        peak_d = peak_q;
        if (clear_i)                peak_d = '0;
        else if (count_d > peak_q)  peak_d = count_d;
    end

    // High-water mark register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) peak_q <= '0;
        else       peak_q <= peak_d;
    end

    assign peak_count_o = peak_q;
`else
    assign peak_count_o = '0;
`endif

endmodule

// File: tb/tb_pixel_sync_fifo.sv
// Self-checking bench for pixel_sync_fifo: one registered-read instance and one
// FWFT instance share stimulus; a queue scoreboard holds the expected words.
module tb_pixel_sync_fifo;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF_TH = 6;
    localparam int AE_TH = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;

    logic [DW-1:0] d0_data, d1_data;
    logic          d0_valid, d1_valid;
    logic          d0_full, d1_full, d0_empty, d1_empty;
    logic          d0_af, d1_af, d0_ae, d1_ae;
    logic [AW:0]   d0_count, d1_count;
    logic          d0_ovf, d1_ovf, d0_udf, d1_udf;
    logic [AW:0]   d0_peak, d1_peak;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] exp_q[$];
    bit            m_ovf;
    bit            m_udf;
    int            m_peak;

    // Expected value of every output right after reset or flush (count..peak order below).
    logic [30:0] rst_exp;
    logic [30:0] rst_obs;

    always #5 clk = ~clk;

    pixel_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH),
        .ALMOST_EMPTY_TH(AE_TH), .FWFT(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .wr_i(wr), .data_i(din), .rd_i(rd),
        .data_o(d0_data), .valid_o(d0_valid), .full_o(d0_full), .empty_o(d0_empty),
        .almost_full_o(d0_af), .almost_empty_o(d0_ae), .count_o(d0_count),
        .overflow_o(d0_ovf), .underflow_o(d0_udf), .peak_count_o(d0_peak)
    );

    pixel_sync_fifo #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ALMOST_FULL_TH(AF_TH),
        .ALMOST_EMPTY_TH(AE_TH), .FWFT(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .clear_i(clear), .wr_i(wr), .data_i(din), .rd_i(rd),
        .data_o(d1_data), .valid_o(d1_valid), .full_o(d1_full), .empty_o(d1_empty),
        .almost_full_o(d1_af), .almost_empty_o(d1_ae), .count_o(d1_count),
        .overflow_o(d1_ovf), .underflow_o(d1_udf), .peak_count_o(d1_peak)
    );

    function automatic int exp_peak();
`ifdef PIXEL_SYNC_FIFO_PEAK_EN
        return m_peak;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_peak = 0;
    endtask

    // One clock of traffic: model acceptance, scoreboard push/pop, compare after the edge.
    task automatic drive_cycle(input bit w, input bit r, input logic [DW-1:0] d);
        int            cnt;
        bit            a_rd;
        bit            a_wr;
        logic [DW-1:0] e;
        logic [8:0]    st_obs;
        logic [8:0]    st_exp;
        cnt  = exp_q.size();
        a_rd = r && (cnt > 0);
        a_wr = w && ((cnt < DEPTH) || a_rd);
        wr = w; rd = r; din = d;
        n_cmp++;
        if (cnt > 0) begin
            if (d1_valid !== 1'b1 || d1_data !== exp_q[0]) begin
                n_err++;
                $display("FAIL fwft_head: got data=%0h valid=%b, want data=%0h valid=1", d1_data, d1_valid, exp_q[0]);
            end
        end else if (d1_valid !== 1'b0) begin
            n_err++;
            $display("FAIL fwft_empty_valid: got valid=%b, want 0", d1_valid);
        end
        e = '0;
        if (a_rd) e = exp_q.pop_front();
        if (a_wr) exp_q.push_back(d);
        if (w && !a_wr) m_ovf = 1'b1;
        if (r && !a_rd) m_udf = 1'b1;
        if (exp_q.size() > m_peak) m_peak = exp_q.size();
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        n_cmp++;
        if (d0_valid !== a_rd || (a_rd && d0_data !== e)) begin
            n_err++;
            $display("FAIL reg_read: got data=%0h valid=%b, want data=%0h valid=%b", d0_data, d0_valid, e, a_rd);
        end
        cnt    = exp_q.size();
        st_exp = {4'(cnt), cnt == DEPTH, cnt == 0, cnt >= AF_TH, cnt <= AE_TH, m_ovf};
        st_obs = {d0_count, d0_full, d0_empty, d0_af, d0_ae, d0_ovf};
        n_cmp++;
        if (st_obs !== st_exp || d0_udf !== m_udf) begin
            n_err++;
            $display("FAIL status: got cnt/full/empty/af/ae/ovf=%b udf=%b, want %b udf=%b", st_obs, d0_udf, st_exp, m_udf);
        end
        n_cmp++;
        if (d1_count !== 4'(cnt) || d1_ovf !== m_ovf || d1_udf !== m_udf) begin
            n_err++;
            $display("FAIL fwft_status: got cnt=%0d ovf=%b udf=%b, want cnt=%0d ovf=%b udf=%b", d1_count, d1_ovf, d1_udf, cnt, m_ovf, m_udf);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wr = 1'b0; rd = 1'b0; din = '0;
        model_reset();
        @(posedge clk); #1;
        rst_obs = {d0_count, d0_empty, d0_full, d0_af, d0_ae, d0_valid, d0_data, d0_ovf, d0_udf, d0_peak};
        n_cmp++;
        if (rst_obs !== rst_exp) begin
            n_err++;
            $display("FAIL reset_state: got %b, want %b", rst_obs, rst_exp);
        end
        n_cmp++;
        if ({d1_count, d1_valid, d1_data, d1_empty} !== {4'd0, 1'b0, 16'h0, 1'b1}) begin
            n_err++;
            $display("FAIL reset_fwft: got cnt=%0d valid=%b data=%0h empty=%b, want 0/0/0/1", d1_count, d1_valid, d1_data, d1_empty);
        end
        #3 rst = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 16'h1000 + 16'(i));
        drive_cycle(1'b1, 1'b0, 16'h10FF);
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b0, 1'b1, '0);
        do_clear();
    endtask

    task automatic test_full_rw();
        logic [DW-1:0] last;
        for (int i = 0; i < DEPTH; i++) drive_cycle(1'b1, 1'b0, 16'h2000 + 16'(i));
        drive_cycle(1'b1, 1'b1, 16'hBEEF);
        last = '0;
        for (int i = 0; i < DEPTH; i++) begin
            drive_cycle(1'b0, 1'b1, '0);
            last = d0_data;
        end
        n_cmp++;
        if (last !== 16'hBEEF) begin
            n_err++;
            $display("FAIL full_rw_last: got %0h, want beef", last);
        end
        do_clear();
    endtask

    task automatic test_empty_rw();
        drive_cycle(1'b1, 1'b1, 16'h00AA);
        n_cmp++;
        if (d1_data !== 16'h00AA || d1_valid !== 1'b1 || d0_udf !== 1'b1) begin
            n_err++;
            $display("FAIL empty_rw: got fwft data=%0h valid=%b udf=%b, want aa/1/1", d1_data, d1_valid, d0_udf);
        end
        drive_cycle(1'b0, 1'b1, '0);
        do_clear();
    endtask

    task automatic test_stream();
        for (int i = 0; i < 3; i++) drive_cycle(1'b1, 1'b0, 16'h3000 + 16'(i));
        for (int i = 3; i < 23; i++) drive_cycle(1'b1, 1'b1, 16'h3000 + 16'(i));
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b1, '0);
        do_clear();
    endtask

    task automatic test_clear();
        drive_cycle(1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 16'h4000 + 16'(i));
        clear = 1'b1; wr = 1'b1; din = 16'h5555;
        @(posedge clk); #1;
        clear = 1'b0; wr = 1'b0;
        model_reset();
        rst_obs = {d0_count, d0_empty, d0_full, d0_af, d0_ae, d0_valid, d0_data, d0_ovf, d0_udf, d0_peak};
        n_cmp++;
        if (rst_obs !== rst_exp) begin
            n_err++;
            $display("FAIL clear_state: got %b, want %b", rst_obs, rst_exp);
        end
        n_cmp++;
        if ({d1_count, d1_valid, d1_data, d1_empty, d1_udf} !== {4'd0, 1'b0, 16'h0, 1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL clear_fwft: got cnt=%0d valid=%b data=%0h empty=%b udf=%b, want 0/0/0/1/0", d1_count, d1_valid, d1_data, d1_empty, d1_udf);
        end
    endtask

    task automatic test_peak();
        for (int i = 0; i < 7; i++) drive_cycle(1'b1, 1'b0, 16'h6000 + 16'(i));
        for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b1, '0);
        n_cmp++;
        if (d0_peak !== 4'(exp_peak()) || d1_peak !== 4'(exp_peak())) begin
            n_err++;
            $display("FAIL peak: got %0d/%0d, want %0d", d0_peak, d1_peak, exp_peak());
        end
        do_clear();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 4; i++) drive_cycle(1'b1, 1'b0, 16'h7000 + 16'(i));
        drive_cycle(1'b0, 1'b1, '0);
        wr = 1'b1; rd = 1'b1; din = 16'h7777;
        #2 rst = 1'b1;
        #1;
        rst_obs = {d0_count, d0_empty, d0_full, d0_af, d0_ae, d0_valid, d0_data, d0_ovf, d0_udf, d0_peak};
        n_cmp++;
        if (rst_obs !== rst_exp) begin
            n_err++;
            $display("FAIL async_reset: got %b, want %b", rst_obs, rst_exp);
        end
        n_cmp++;
        if ({d1_count, d1_valid, d1_data, d1_peak} !== {4'd0, 1'b0, 16'h0, 4'd0}) begin
            n_err++;
            $display("FAIL async_reset_fwft: got cnt=%0d valid=%b data=%0h peak=%0d, want 0", d1_count, d1_valid, d1_data, d1_peak);
        end
        #1 rst = 1'b0; wr = 1'b0; rd = 1'b0;
        model_reset();
        drive_cycle(1'b1, 1'b0, 16'h8001);
        drive_cycle(1'b0, 1'b1, '0);
    endtask

    initial begin
        rst_exp = {4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 4'd0};
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_stream();
        test_clear();
        test_peak();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
